gpio_ctrl_top: RTL and testbench
================================

// Module: gpio_ctrl_top
// PURPOSE
//  32-bit general-purpose I/O controller on the APB peripheral bus.
//  Drives 32 output pins from a software-written register and lets software read back 32 input pins.
//  Input pins are synchronised into sys_clk.
//  Zero-wait-state APB slave; lives in the peripheral subsystem beside the other APB register blocks.
// PARAMETERS
//  SYNC_STAGES  2             flip-flop stages on gpio_in before it reaches any register (allowed >=2)
//  ID_VALUE     32'h4750494F  constant returned by the ID register ("GPIO")
// PORTS
//  sys_clk  in   1   single system clock; all state is on its rising edge
//  rst      in   1   reset, asynchronous and active-high
//  paddr    in   16  APB byte address
//  pwrite   in   1   APB direction: 1 = write, 0 = read
//  psel     in   1   APB select
//  penable  in   1   APB enable (access phase)
//  pstrb    in   4   APB byte-lane write strobes; pstrb[n] covers bits [8n+7:8n]
//  pwdata   in   32  APB write data
//  prdata   out  32  APB read data
//  pready   out  1   APB ready; tied 1
//  pslverr  out  1   APB error response
//  gpio_in  in   32  asynchronous input pins
//  gpio_out out  32  output pins, driven straight from the OUT register
//  gpio_irq out  1   level interrupt; 0 unless GPIO_IRQ_EN is defined
// BEHAVIOUR
//  Reset (rst=1, asynchronous): OUT=0, sync chain=0, prdata=0, gpio_out=0, gpio_irq=0.
//   pslverr is 0 while psel=0.
//  Address decode: paddr[15:2] selects the word; paddr[1:0] is ignored.
//  Register map:
//   0x00 OUT     RW  gpio_out value; byte-masked by pstrb
//   0x04 TGL     WO  write 1 toggles the matching OUT bit (pstrb-masked); reads 0
//   0x08 IN      RO  synchronised gpio_in
//   0x0C ID      RO  ID_VALUE
//   0x10 EDGE    W1C rising-edge status (GPIO_IRQ_EN only)
//   0x14 IRQ_EN  RW  interrupt mask per bit (GPIO_IRQ_EN only)
//  APB protocol:
//   - pready is always 1, so every transfer is exactly setup + one access cycle.
//   - Write commits on the rising edge where psel & penable & pwrite.
//   - Read data is registered: prdata loads on the edge where psel & !penable & !pwrite (end of setup phase).
//   - prdata holds its value until the next read setup phase, so it is valid throughout the access phase.
//  Error response:
//   - pslverr = psel & penable & (unmapped word | write to IN or ID); combinational.
//   - An errored write changes no state; an errored read returns 0.
//  pstrb=0 on a write: no register changes, no error.
//  Timing and edge cases:
//   - gpio_out changes the cycle after the commit edge, i.e. 1-cycle latency from the access phase.
//   - IN reflects a gpio_in change SYNC_STAGES cycles after it; there is no glitch filtering.
//   - rst asserted mid-transfer aborts the transfer; nothing is committed; registers return to reset values.
//   - OUT and TGL cannot be written in the same cycle, since APB allows one transfer at a time.
// CONFIGURATION
//  Macro GPIO_IRQ_EN.
//  Defined:
//   - EDGE bit n sets when synced gpio_in[n] goes 0->1.
//   - Writing 1 to an EDGE bit clears it. If a set and a clear hit the same cycle, the set wins.
//   - gpio_irq = |(EDGE & IRQ_EN), registered.
//   - EDGE and IRQ_EN reset to 0.
//  Undefined:
//   - 0x10 and 0x14 are unmapped and give pslverr.
//   - gpio_irq is tied 0; no edge logic is built.
// TESTING
//  1. Reset: hold rst=1 for 100 ns with gpio_in=0x90ABCDEF -> gpio_out=0, prdata=0, pslverr=0, pready=1.
//  2. Write 0x00 with pwdata 0x12345678, pstrb 1111 -> gpio_out=0x12345678 the cycle after the access phase; pslverr=0.
//  3. Read 0x08 with gpio_in=0x90ABCDEF held stable -> prdata=0x90ABCDEF in the access phase.
//     Read 0x0C -> prdata=0x4750494F.
//  4. Partial and toggle writes, starting from OUT=0x12345678:
//     - write 0x00 pwdata 0xFFFFFFFF, pstrb 0010 -> OUT=0x1234FF78
//     - then write 0x04 pwdata 0x000000FF, pstrb 0001 -> OUT=0x1234FF87
//  5. Errors:
//     - write 0x08 -> pslverr=1 in the access phase; IN is unaffected
//     - read 0x40 -> pslverr=1, prdata=0
//     - the following good read gives pslverr=0
//  6. GPIO_IRQ_EN defined:
//     - IRQ_EN=0x1, gpio_in[0] 0->1 -> EDGE=0x1 and gpio_irq=1 within SYNC_STAGES+2 cycles
//     - write 0x10 with 0x1 -> gpio_irq=0

Source files
------------

// File: rtl/gpio_ctrl_top.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl_top
// Description : 32-bit APB GPIO controller with OUT/TGL/IN/ID registers and
//               synchronised inputs. Define GPIO_IRQ_EN to build the
//               rising-edge status (EDGE), interrupt mask (IRQ_EN) and gpio_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl_top #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h4750494F
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [15:0] paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [3:0]  pstrb,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        gpio_irq
);

    localparam logic [13:0] c_word_out    = 14'd0;
    localparam logic [13:0] c_word_tgl    = 14'd1;
    localparam logic [13:0] c_word_in     = 14'd2;
    localparam logic [13:0] c_word_id     = 14'd3;
    localparam logic [13:0] c_word_edge   = 14'd4;
    localparam logic [13:0] c_word_irq_en = 14'd5;

    logic [13:0] w_word;
    logic [31:0] w_mask;
    logic        w_is_out;
    logic        w_is_tgl;
    logic        w_is_in;
    logic        w_is_id;
    logic        w_is_edge;
    logic        w_is_irq_en;
    logic        w_mapped;
    logic        w_err_cond;
    logic        w_wr_en;
    logic        w_rd_en;
    logic [31:0] w_rd_mux;
    logic        w_unused_paddr;

    logic [31:0]                  r_out_q;
    logic [31:0]                  w_out_d;
    logic [31:0]                  r_prdata_q;
    logic [31:0]                  w_prdata_d;
    logic [SYNC_STAGES-1:0][31:0] r_sync_q;
    logic [SYNC_STAGES-1:0][31:0] w_sync_d;
    logic [31:0]                  w_sync_in;

    // Byte lanes within the word are irrelevant: decode is word-granular.
    assign w_unused_paddr = ^paddr[1:0];

    always_comb begin
        w_word      = paddr[15:2];
        w_mask      = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
        w_is_out    = (w_word == c_word_out);
        w_is_tgl    = (w_word == c_word_tgl);
        w_is_in     = (w_word == c_word_in);
        w_is_id     = (w_word == c_word_id);
        w_is_edge   = (w_word == c_word_edge);
        w_is_irq_en = (w_word == c_word_irq_en);
`ifdef GPIO_IRQ_EN
        w_mapped    = w_is_out | w_is_tgl | w_is_in | w_is_id | w_is_edge | w_is_irq_en;
`else
        w_mapped    = w_is_out | w_is_tgl | w_is_in | w_is_id;
`endif
        w_err_cond  = !w_mapped | (pwrite & (w_is_in | w_is_id));
        w_wr_en     = psel & penable & pwrite & !w_err_cond;
        w_rd_en     = psel & !penable & !pwrite;
    end

    assign pready  = 1'b1;
    assign pslverr = psel & penable & w_err_cond;

    // Input synchroniser: stage 0 samples the pin, the last stage feeds registers.
    always_comb begin
        w_sync_d = r_sync_q;
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            w_sync_d[i] = r_sync_q[i-1];
        end
        w_sync_d[0] = gpio_in;
    end

    assign w_sync_in = r_sync_q[SYNC_STAGES-1];

    // OUT and TGL share one flop; only one transfer can commit per cycle.
    always_comb begin
        w_out_d = r_out_q;
        if (w_wr_en && w_is_out) begin
            w_out_d = (r_out_q & ~w_mask) | (pwdata & w_mask);
        end else if (w_wr_en && w_is_tgl) begin
            w_out_d = r_out_q ^ (pwdata & w_mask);
        end
    end

`ifdef GPIO_IRQ_EN
    logic [31:0] r_in_dly_q;
    logic [31:0] w_in_dly_d;
    logic [31:0] r_edge_q;
    logic [31:0] w_edge_d;
    logic [31:0] r_irq_en_q;
    logic [31:0] w_irq_en_d;
    logic        r_irq_q;
    logic        w_irq_d;
    logic [31:0] w_rise;
    logic [31:0] w_edge_clr;

    // Set has priority over a same-cycle W1C clear.
    always_comb begin
        w_in_dly_d = w_sync_in;
        w_rise     = w_sync_in & ~r_in_dly_q;
        w_edge_clr = (w_wr_en && w_is_edge) ? (pwdata & w_mask) : 32'h0;
        w_edge_d   = (r_edge_q & ~w_edge_clr) | w_rise;
        w_irq_en_d = r_irq_en_q;
        if (w_wr_en && w_is_irq_en) begin
            w_irq_en_d = (r_irq_en_q & ~w_mask) | (pwdata & w_mask);
        end
        w_irq_d    = |(r_edge_q & r_irq_en_q);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_in_dly_q <= 32'h0;
            r_edge_q   <= 32'h0;
            r_irq_en_q <= 32'h0;
            r_irq_q    <= 1'b0;
        end else begin
            r_in_dly_q <= w_in_dly_d;
            r_edge_q   <= w_edge_d;
            r_irq_en_q <= w_irq_en_d;
            r_irq_q    <= w_irq_d;
        end
    end

    assign gpio_irq = r_irq_q;
`else
    assign gpio_irq = 1'b0;
`endif

    // Unmapped words and the write-only TGL read back as zero.
    always_comb begin
        w_rd_mux = 32'h0;
        if (w_is_out) begin
            w_rd_mux = r_out_q;
        end else if (w_is_in) begin
            w_rd_mux = w_sync_in;
        end else if (w_is_id) begin
            w_rd_mux = ID_VALUE;
        end
`ifdef GPIO_IRQ_EN
        else if (w_is_edge) begin
            w_rd_mux = r_edge_q;
        end else if (w_is_irq_en) begin
            w_rd_mux = r_irq_en_q;
        end
`endif
        w_prdata_d = w_rd_en ? w_rd_mux : r_prdata_q;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_out_q    <= 32'h0;
            r_prdata_q <= 32'h0;
            r_sync_q   <= '0;
        end else begin
            r_out_q    <= w_out_d;
            r_prdata_q <= w_prdata_d;
            r_sync_q   <= w_sync_d;
        end
    end

    assign gpio_out = r_out_q;
    assign prdata   = r_prdata_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl_top
// Description : Table-driven APB bench for gpio_ctrl_top, plus reset-abort
//               and (with GPIO_IRQ_EN) edge/interrupt sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl_top;

    localparam int c_sync = 2;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        gpio_irq;

    int n_vec = 0;
    int n_bad = 0;

    gpio_ctrl_top #(
        .SYNC_STAGES (c_sync),
        .ID_VALUE    (32'h4750494F)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pstrb    (pstrb),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_irq (gpio_irq)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] gin;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One setup+access transfer; rdata/err sampled mid access phase,
    // returns after the commit edge at the following negedge.
    task automatic apb(input logic wr, input logic [15:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        @(negedge sys_clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pstrb   = strb;
        pwdata  = wdata;
        @(negedge sys_clk);
        penable = 1'b1;
        #1;
        rdata = prdata;
        err   = pslverr;
        @(negedge sys_clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        vt[0]  = '{1'b1, 16'h0000, 4'hF, 32'h12345678, 32'h90ABCDEF, 32'h0,        1'b0, 32'h12345678};
        vt[1]  = '{1'b0, 16'h0008, 4'h0, 32'h0,        32'h90ABCDEF, 32'h90ABCDEF, 1'b0, 32'h12345678};
        vt[2]  = '{1'b0, 16'h000C, 4'h0, 32'h0,        32'h90ABCDEF, 32'h4750494F, 1'b0, 32'h12345678};
        vt[3]  = '{1'b1, 16'h0000, 4'h2, 32'hFFFFFFFF, 32'h90ABCDEF, 32'h0,        1'b0, 32'h1234FF78};
        vt[4]  = '{1'b1, 16'h0004, 4'h1, 32'h000000FF, 32'h90ABCDEF, 32'h0,        1'b0, 32'h1234FF87};
        vt[5]  = '{1'b1, 16'h0008, 4'hF, 32'hFFFFFFFF, 32'h90ABCDEF, 32'h0,        1'b1, 32'h1234FF87};
        vt[6]  = '{1'b0, 16'h0008, 4'h0, 32'h0,        32'h90ABCDEF, 32'h90ABCDEF, 1'b0, 32'h1234FF87};
        vt[7]  = '{1'b0, 16'h0040, 4'h0, 32'h0,        32'h90ABCDEF, 32'h0,        1'b1, 32'h1234FF87};
        vt[8]  = '{1'b0, 16'h0000, 4'h0, 32'h0,        32'h90ABCDEF, 32'h1234FF87, 1'b0, 32'h1234FF87};
        vt[9]  = '{1'b0, 16'h0004, 4'h0, 32'h0,        32'h90ABCDEF, 32'h0,        1'b0, 32'h1234FF87};
        vt[10] = '{1'b1, 16'h0000, 4'h0, 32'hFFFFFFFF, 32'h90ABCDEF, 32'h0,        1'b0, 32'h1234FF87};
        vt[11] = '{1'b0, 16'h000E, 4'h0, 32'h0,        32'h90ABCDEF, 32'h4750494F, 1'b0, 32'h1234FF87};
        vt[12] = '{1'b1, 16'h000C, 4'hF, 32'h0,        32'h90ABCDEF, 32'h0,        1'b1, 32'h1234FF87};
        vt[13] = '{1'b1, 16'h0004, 4'hF, 32'hFFFFFFFF, 32'h90ABCDEF, 32'h0,        1'b0, 32'hEDCB0078};
        vt[14] = '{1'b1, 16'h0000, 4'h9, 32'hAABBCCDD, 32'h90ABCDEF, 32'h0,        1'b0, 32'hAACB00DD};
        vt[15] = '{1'b0, 16'h0008, 4'h0, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 32'hAACB00DD};
        vt[16] = '{1'b0, 16'h0001, 4'h0, 32'h0,        32'h0F0F0F0F, 32'hAACB00DD, 1'b0, 32'hAACB00DD};

        rst     = 1'b1;
        paddr   = 16'h0;
        pwrite  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pstrb   = 4'h0;
        pwdata  = 32'h0;
        gpio_in = 32'h90ABCDEF;
        #100;
        chk("reset gpio_out", gpio_out, 32'h0);
        chk("reset prdata",   prdata,   32'h0);
        chk("reset pslverr",  {31'h0, pslverr}, 32'h0);
        chk("reset pready",   {31'h0, pready},  32'h1);
        chk("reset gpio_irq", {31'h0, gpio_irq}, 32'h0);
        @(negedge sys_clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            gpio_in = vt[i].gin;
            repeat (c_sync + 1) @(negedge sys_clk);
            apb(vt[i].wr, vt[i].addr, vt[i].strb, vt[i].wdata, rd, er);
            chk($sformatf("vec%0d pslverr", i), {31'h0, er}, {31'h0, vt[i].exp_err});
            chk($sformatf("vec%0d gpio_out", i), gpio_out, vt[i].exp_out);
            if (!vt[i].wr) begin
                chk($sformatf("vec%0d prdata", i), rd, vt[i].exp_rd);
            end
        end

        // Reset asserted during an access phase aborts the write.
        @(negedge sys_clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0000;
        pstrb   = 4'hF;
        pwdata  = 32'h55555555;
        @(negedge sys_clk);
        penable = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("abort async gpio_out", gpio_out, 32'h0);
        @(negedge sys_clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        rst     = 1'b0;
        @(negedge sys_clk);
        chk("abort gpio_out", gpio_out, 32'h0);
        apb(1'b0, 16'h0000, 4'h0, 32'h0, rd, er);
        chk("abort OUT readback", rd, 32'h0);

`ifdef GPIO_IRQ_EN
        gpio_in = 32'h0;
        repeat (c_sync + 3) @(negedge sys_clk);
        apb(1'b1, 16'h0010, 4'hF, 32'hFFFFFFFF, rd, er);
        apb(1'b0, 16'h0010, 4'h0, 32'h0, rd, er);
        chk("edge cleared", rd, 32'h0);
        apb(1'b1, 16'h0014, 4'hF, 32'h00000001, rd, er);
        chk("irq_en write err", {31'h0, er}, 32'h0);
        apb(1'b0, 16'h0014, 4'h0, 32'h0, rd, er);
        chk("irq_en readback", rd, 32'h1);
        chk("irq idle", {31'h0, gpio_irq}, 32'h0);
        @(negedge sys_clk);
        gpio_in = 32'h00000001;
        repeat (c_sync + 2) @(posedge sys_clk);
        #1;
        chk("irq asserted", {31'h0, gpio_irq}, 32'h1);
        apb(1'b0, 16'h0010, 4'h0, 32'h0, rd, er);
        chk("edge set", rd, 32'h1);
        apb(1'b1, 16'h0010, 4'hF, 32'h00000001, rd, er);
        repeat (2) @(negedge sys_clk);
        chk("irq cleared", {31'h0, gpio_irq}, 32'h0);
`else
        apb(1'b0, 16'h0010, 4'h0, 32'h0, rd, er);
        chk("edge unmapped err", {31'h0, er}, 32'h1);
        chk("edge unmapped rd", rd, 32'h0);
        apb(1'b1, 16'h0014, 4'hF, 32'hFFFFFFFF, rd, er);
        chk("irq_en unmapped err", {31'h0, er}, 32'h1);
        gpio_in = 32'hFFFFFFFF;
        repeat (c_sync + 3) @(negedge sys_clk);
        chk("irq tied low", {31'h0, gpio_irq}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
